// File: rtl/tage_fold_hash.sv
// TAGE index/tag generator: speculative global/path history with per-table
// circular folds kept up to date one outcome at a time, plus a single checkpoint.
module tage_fold_hash #(
    parameter int                NTAB      = 4,
    parameter int                IL        = 10,
    parameter int                TL        = 8,
    parameter int                PC_LEN    = 32,
    parameter int                PLEN      = 16,
    parameter int                GLOB_LEN  = 131,
    parameter logic [NTAB*16-1:0] HIST_LENS = {16'd131, 16'd44, 16'd15, 16'd5}
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 push_valid,
    input  logic                 push_taken,
    input  logic                 push_path,
    input  logic                 ckpt_save,
    input  logic                 ckpt_restore,
    input  logic                 lk_valid,
    input  logic [PC_LEN-1:0]    lk_pc,
    output logic                 out_valid,
    output logic [NTAB*IL-1:0]   out_index,
    output logic [NTAB*TL-1:0]   out_tag
);

    logic [GLOB_LEN-1:0] ghist_reg, ghist_shadow_reg;
    logic [PLEN-1:0]     phist_reg, phist_shadow_reg;
    logic [NTAB*IL-1:0]  index_next;
    logic [NTAB*TL-1:0]  tag_next;
    logic                out_valid_reg;
    logic [NTAB*IL-1:0]  out_index_reg;
    logic [NTAB*TL-1:0]  out_tag_reg;

    // A restore wins over a push; a save always captures the pre-edge state
    // unless it collides with a restore, in which case the shadow is kept.
    always_ff @(posedge CLK) begin
        if (reset) begin
            ghist_reg        <= '0;
            phist_reg        <= '0;
            ghist_shadow_reg <= '0;
            phist_shadow_reg <= '0;
        end else begin
            if (ckpt_restore) begin
                ghist_reg <= ghist_shadow_reg;
                phist_reg <= phist_shadow_reg;
            end else if (push_valid) begin
                ghist_reg <= {ghist_reg[GLOB_LEN-2:0], push_taken};
                phist_reg <= {phist_reg[PLEN-2:0], push_path};
            end
            if (ckpt_save && !ckpt_restore) begin
                ghist_shadow_reg <= ghist_reg;
                phist_shadow_reg <= phist_reg;
            end
        end
    end

    for (genvar gi = 0; gi < NTAB; gi++) begin : g_tab
        localparam int L   = int'(HIST_LENS[gi*16 +: 16]);
        localparam int SI  = L % IL;
        localparam int ST0 = L % TL;
        localparam int ST1 = L % (TL - 1);
        localparam int R   = gi % IL;

        logic [IL-1:0] fi_reg, fi_shadow_reg, fi_next;
        logic [TL-1:0] ft0_reg, ft0_shadow_reg, ft0_next;
        logic [TL-2:0] ft1_reg, ft1_shadow_reg, ft1_next;
        logic [IL-1:0] p_base, p_rot;
        logic          outgoing;

        assign outgoing = ghist_reg[L-1];

        // Rotate, inject the new bit at 0, cancel the bit leaving the window.
        always_comb begin
            fi_next       = (fi_reg << 1) | (fi_reg >> (IL - 1));
            fi_next[0]    = fi_next[0] ^ push_taken;
            fi_next[SI]   = fi_next[SI] ^ outgoing;
            ft0_next      = (ft0_reg << 1) | (ft0_reg >> (TL - 1));
            ft0_next[0]   = ft0_next[0] ^ push_taken;
            ft0_next[ST0] = ft0_next[ST0] ^ outgoing;
            ft1_next      = (ft1_reg << 1) | (ft1_reg >> (TL - 2));
            ft1_next[0]   = ft1_next[0] ^ push_taken;
            ft1_next[ST1] = ft1_next[ST1] ^ outgoing;
        end

        always_ff @(posedge CLK) begin
            if (reset) begin
                fi_reg         <= '0;
                ft0_reg        <= '0;
                ft1_reg        <= '0;
                fi_shadow_reg  <= '0;
                ft0_shadow_reg <= '0;
                ft1_shadow_reg <= '0;
            end else begin
                if (ckpt_restore) begin
                    fi_reg  <= fi_shadow_reg;
                    ft0_reg <= ft0_shadow_reg;
                    ft1_reg <= ft1_shadow_reg;
                end else if (push_valid) begin
                    fi_reg  <= fi_next;
                    ft0_reg <= ft0_next;
                    ft1_reg <= ft1_next;
                end
                if (ckpt_save && !ckpt_restore) begin
                    fi_shadow_reg  <= fi_reg;
                    ft0_shadow_reg <= ft0_reg;
                    ft1_shadow_reg <= ft1_reg;
                end
            end
        end

        assign p_base = phist_reg[IL-1:0];
        assign p_rot  = (p_base << R) | (p_base >> (IL - R));

        assign index_next[gi*IL +: IL] = lk_pc[IL-1:0] ^ lk_pc[2*IL-1:IL] ^ fi_reg ^ p_rot;
        assign tag_next[gi*TL +: TL]   = lk_pc[TL-1:0] ^ ft0_reg ^ {ft1_reg, 1'b0};
    end

    if (PC_LEN > 2*IL) begin : g_pc_high
        logic unused_pc_high;
        assign unused_pc_high = ^lk_pc[PC_LEN-1:2*IL];
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_index_reg <= '0;
            out_tag_reg   <= '0;
        end else begin
            out_valid_reg <= lk_valid;
            if (lk_valid) begin
                out_index_reg <= index_next;
                out_tag_reg   <= tag_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_index = out_index_reg;
    assign out_tag   = out_tag_reg;

endmodule

// File: doc/tage_fold_hash.md
# tage_fold_hash

Multi-table TAGE index/tag generator with incrementally maintained folded histories. It owns the speculative global and path history and keeps a per-table circular-folded compression of each table's history length. It produces one index and one tag per tagged table for every lookup PC. It sits between the fetch-stage PC and the tagged-table banks, and supports a single checkpoint for misprediction recovery.

## Interface
- NTAB, 4: number of tagged tables (channels)
- IL, 10: index width per table
- TL, 8: tag width per table; must be ≥2
- PC_LEN, 32: PC width; must be ≥2*IL and ≥TL
- PLEN, 16: path history width; must be ≥IL
- GLOB_LEN, 131: global history register depth
- HIST_LENS, {16'd131,16'd44,16'd15,16'd5}: packed per-table history lengths, 16 bits each, table 0 in bits [15:0]
  - Each length must be in 1..GLOB_LEN.

Ports:
- CLK  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- push_valid  in  1  shift one branch outcome into history
- push_taken  in  1  outcome bit shifted into ghist[0]
- push_path  in  1  path bit shifted into phist[0]
- ckpt_save  in  1  copy current history state into checkpoint
- ckpt_restore  in  1  load history state from checkpoint
- lk_valid  in  1  lookup request
- lk_pc  in  PC_LEN  lookup PC
- out_valid  out  1  lookup result valid
- out_index  out  NTAB*IL  table t index at [t*IL +: IL]
- out_tag  out  NTAB*TL  table t tag at [t*TL +: TL]

## Operation
- State: ghist[GLOB_LEN], phist[PLEN], and per table t with length L=HIST_LENS[t]:
  - fi_t (IL bits)
  - ft0_t (TL bits)
  - ft1_t (TL-1 bits)
- Fold update of width W on push, where o = ghist[L-1] before the shift:
  - f' = rotl1(f) ^ push_taken at bit 0 ^ (o << (L mod W))
  - Invariant: f == XOR of the W-bit chunks of ghist[L-1:0]. The bench checks this against a reference model every cycle.
- Push:
  - ghist ← {ghist[GLOB_LEN-2:0], push_taken}
  - phist ← {phist[PLEN-2:0], push_path}
  - All folds update in the same cycle.
- Hash for table t, with P = phist[IL-1:0] rotated left by (t mod IL):
  - index_t = lk_pc[IL-1:0] ^ lk_pc[2*IL-1:IL] ^ fi_t ^ P
  - tag_t = lk_pc[TL-1:0] ^ ft0_t ^ {ft1_t,1'b0}
- Checkpoint:
  - ckpt_save copies ghist, phist and all folds into a shadow set.
  - ckpt_restore copies the shadow set back.
  - The shadow set is zero after reset.
- Simultaneous events, in priority order:
  - reset > ckpt_restore > push_valid.
  - When restore and push coincide, the push is dropped.
  - When save and push coincide, the pre-push state is saved.
  - When save and restore coincide, the restore is applied and the shadow set is unchanged.
- Lookups are independent of push/save/restore and may occur every cycle.

## Timing
- Lookup latency is 1 cycle.
  - lk_valid at edge N gives out_valid=1 and results during cycle N+1.
  - Results are hashed from state as it stood before edge N; a push at the same edge is not visible.
- out_valid is a single-cycle pulse per lookup. Back-to-back lookups give continuous out_valid.
- out_index and out_tag hold their last value when no lookup is issued.
- Push and restore take effect at the edge. A lookup in the following cycle sees the new state.
- Reset values:
  - out_valid=0, out_index=0, out_tag=0
  - ghist, phist, all folds and the shadow set = 0
  - Reset asserted mid-stream drops any lookup issued on the same edge.
- No backpressure: the consumer must accept every out_valid pulse.

## Test plan
- Reset then lookup with lk_pc=0: next cycle out_valid=1, every index=0, every tag=0.
- Six pushes with push_taken=1, push_path=0, then lookup with lk_pc=0. Table 0 (L=5) must give:
  - index=0x01F (wrap: the sixth push cancels the outgoing bit)
  - ft0=0x1F, ft1=0x1F, tag=0x21
- 200 random pushes with a lookup every cycle: every fold matches the chunk-XOR reference for all tables. Covers L=131 wrapping GLOB_LEN and L mod W ≠ 0.
- Save after 10 pushes, push 7 more, restore, then lookup: outputs equal those of a lookup taken right after the save.
- Restore and push in the same cycle: push dropped. Save and push in the same cycle: the shadow set holds the pre-push state.
- lk_valid, push and reset asserted on the same edge: next cycle out_valid=0 and all state is zero. Lookups stream with no gaps afterwards.
